// File: rtl/viterbi_ctrl_if.sv
// Frame-bus handshake between the upstream frame source and the Viterbi sequencer.
// The source drives frame_valid; the sequencer answers with frame_ready.
interface viterbi_ctrl_if;
    logic frame_valid;
    logic frame_ready;

    modport master (output frame_valid, input frame_ready);
    modport slave  (input frame_valid, output frame_ready);
endinterface

// File: rtl/viterbi_ctrl.sv
// Viterbi decoder sequencer: accepts frames, issues slice beats per code rate,
// pipelines BM/ACS enables, runs traceback and signals completion. PIPE_LAT >= 2.
module viterbi_ctrl #(
    parameter int FRAME_W  = 24,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_code_rate,
    input  logic [CNT_W-1:0] i_num_frames,
    viterbi_ctrl_if.slave    frame_bus,
    output logic             o_en_s,
    output logic [3:0]       o_beat,
    output logic             o_en_bm,
    output logic             o_en_acs,
    output logic             o_en_tb,
    input  logic             i_tb_done,
    output logic             o_rate,
    output logic             o_ood,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_sym_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SLICE = 3'd2,
        ST_FLUSH = 3'd3,
        ST_TB    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam int               FL_W       = $clog2(PIPE_LAT + 1);
    localparam logic [3:0]       LAST_R2    = 4'(FRAME_W / 4 - 1);
    localparam logic [3:0]       LAST_R3    = 4'(FRAME_W / 6 - 1);
    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] ONE_FRAME  = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t             state_r, state_nx;
    logic               rate_r, rate_nx;
    logic [CNT_W-1:0]   frames_r, frames_nx;
    logic [CNT_W-1:0]   sym_r, sym_nx;
    logic [3:0]         beat_r, beat_nx;
    logic [FL_W-1:0]    flush_r, flush_nx;
    logic [3:0]         beat_last_s;
    logic               last_beat_s;
    logic               en_s_r, en_s_nx;
    logic               ready_r, ready_nx;
    logic               en_tb_r, en_tb_nx;
    logic               busy_r, busy_nx;
    logic               done_r, done_nx;
    logic               ood_r, ood_nx;
    logic [PIPE_LAT-1:0] dly_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx    = state_r;
        beat_last_s = rate_r ? LAST_R3 : LAST_R2;
        last_beat_s = (beat_r == beat_last_s);
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    state_nx = (i_num_frames == {CNT_W{1'b0}}) ? ST_DONE : ST_WAIT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (frame_bus.frame_valid && ready_r) begin
                    state_nx = ST_SLICE;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_SLICE: begin
                if (last_beat_s) begin
                    state_nx = (frames_r == ONE_FRAME) ? ST_FLUSH : ST_WAIT;
                end else begin
                    state_nx = ST_SLICE;
                end
            end
            ST_FLUSH: begin
                if (flush_r == FLUSH_LAST) begin
                    state_nx = ST_TB;
                end else begin
                    state_nx = ST_FLUSH;
                end
            end
            ST_TB: begin
                if (i_tb_done) begin
                    state_nx = ST_DONE;
                end else begin
                    state_nx = ST_TB;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of job registers and outputs, aligned to the state being entered
    always_comb begin
        rate_nx   = rate_r;
        frames_nx = frames_r;
        sym_nx    = sym_r;
        if (state_r == ST_IDLE && i_start) begin
            rate_nx   = i_code_rate;
            frames_nx = i_num_frames;
            sym_nx    = {CNT_W{1'b0}};
        end else begin
            if (state_r == ST_SLICE && last_beat_s) begin
                frames_nx = frames_r - ONE_FRAME;
            end else begin
                frames_nx = frames_r;
            end
            if (state_nx == ST_SLICE) begin
                sym_nx = sat_inc(sym_r);
            end else begin
                sym_nx = sym_r;
            end
        end
        if (state_nx == ST_SLICE && state_r == ST_SLICE) begin
            beat_nx = beat_r + 4'd1;
        end else begin
            beat_nx = 4'd0;
        end
        if (state_nx == ST_FLUSH && state_r == ST_FLUSH) begin
            flush_nx = flush_r + FL_W'(1);
        end else begin
            flush_nx = {FL_W{1'b0}};
        end
        en_s_nx  = (state_nx == ST_SLICE);
        ready_nx = (state_nx == ST_WAIT);
        en_tb_nx = (state_nx == ST_TB);
        busy_nx  = (state_nx != ST_IDLE);
        done_nx  = (state_nx == ST_DONE);
        ood_nx   = en_s_nx && (beat_nx == beat_last_s) && (frames_nx == ONE_FRAME);
    end

    // Job registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rate_r   <= 1'b0;
            frames_r <= {CNT_W{1'b0}};
            sym_r    <= {CNT_W{1'b0}};
            beat_r   <= 4'd0;
            flush_r  <= {FL_W{1'b0}};
            en_s_r   <= 1'b0;
            ready_r  <= 1'b0;
            en_tb_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ood_r    <= 1'b0;
        end else begin
            rate_r   <= rate_nx;
            frames_r <= frames_nx;
            sym_r    <= sym_nx;
            beat_r   <= beat_nx;
            flush_r  <= flush_nx;
            en_s_r   <= en_s_nx;
            ready_r  <= ready_nx;
            en_tb_r  <= en_tb_nx;
            busy_r   <= busy_nx;
            done_r   <= done_nx;
            ood_r    <= ood_nx;
        end
    end

    // Slice-enable delay line feeding BM and ACS; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_r <= {PIPE_LAT{1'b0}};
        end else begin
            dly_r <= {dly_r[PIPE_LAT-2:0], en_s_r};
        end
    end

    assign frame_bus.frame_ready = ready_r;
    assign o_en_s    = en_s_r;
    assign o_beat    = beat_r;
    assign o_en_bm   = dly_r[0];
    assign o_en_acs  = dly_r[PIPE_LAT-1];
    assign o_en_tb   = en_tb_r;
    assign o_rate    = rate_r;
    assign o_ood     = ood_r;
    assign o_busy    = busy_r;
    assign o_done    = done_r;
    assign o_sym_cnt = sym_r;

endmodule

// File: tb/tb_viterbi_ctrl.sv
// Directed bench for viterbi_ctrl: beat scoreboard, pipeline-lag monitor and
// per-step assertions covering rate, frame count, reset and ignored inputs.
module tb_viterbi_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_code_rate = 1'b0;
    logic [15:0] i_num_frames = 16'd0;
    logic        i_tb_done = 1'b0;
    logic        o_en_s, o_en_bm, o_en_acs, o_en_tb, o_rate, o_ood, o_busy, o_done;
    logic [3:0]  o_beat;
    logic [15:0] o_sym_cnt;

    viterbi_ctrl_if bus ();

    viterbi_ctrl dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_code_rate(i_code_rate),
        .i_num_frames(i_num_frames), .frame_bus(bus), .o_en_s(o_en_s),
        .o_beat(o_beat), .o_en_bm(o_en_bm), .o_en_acs(o_en_acs), .o_en_tb(o_en_tb),
        .i_tb_done(i_tb_done), .o_rate(o_rate), .o_ood(o_ood), .o_busy(o_busy),
        .o_done(o_done), .o_sym_cnt(o_sym_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [3:0] beat_q[$];
    int         n_es = 0, n_ood = 0, n_done = 0, n_tb = 0, n_fr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_es = 0; n_ood = 0; n_done = 0; n_tb = 0; n_fr = 0;
    endtask

    task automatic start_job(input logic rate, input logic [15:0] frames);
        i_code_rate  = rate;
        i_num_frames = frames;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    task automatic send_frame(input int bpf);
        for (int b = 0; b < bpf; b++) beat_q.push_back(4'(b));
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
    endtask

    task automatic wait_tb();
        int n = 0;
        while (!o_en_tb && n < 20) begin
            tick();
            n++;
        end
        check("tb_timeout", o_en_tb, 1);
    endtask

    // Monitor: pops expected beats on each slice enable and checks BM/ACS lag
    initial begin
        logic [1:0] hist = 2'b00;
        logic [3:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                hist = 2'b00;
            end else begin
                check("en_bm_lag", o_en_bm, hist[0]);
                check("en_acs_lag", o_en_acs, hist[1]);
                hist = {hist[0], o_en_s};
                if (o_en_s) begin
                    n_es++;
                    check("beat_expected", 32'(beat_q.size() != 0), 1);
                    if (beat_q.size() != 0) begin
                        exp_b = beat_q.pop_front();
                        check("beat", o_beat, exp_b);
                    end
                end
                if (o_ood) n_ood++;
                if (o_done) n_done++;
                if (o_en_tb) n_tb++;
                if (bus.frame_ready) n_fr++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.frame_valid = 1'b0;
        tick(); tick(); tick();
        check("rst_en_s", o_en_s, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ready", bus.frame_ready, 0);
        check("rst_sym", o_sym_cnt, 0);
        check("rst_done", o_done, 0);
        rst = 1'b0;
        tick();

        // Test 1: rate 1/2, one frame
        clear_mon();
        start_job(1'b0, 16'd1);
        check("t1_ready", bus.frame_ready, 1);
        check("t1_busy", o_busy, 1);
        check("t1_sym0", o_sym_cnt, 0);
        send_frame(6);
        for (int k = 0; k < 6; k++) begin
            check("t1_en_s", o_en_s, 1);
            check("t1_beat", o_beat, k);
            check("t1_en_bm", o_en_bm, 32'(k >= 1));
            check("t1_en_acs", o_en_acs, 32'(k >= 2));
            check("t1_ood", o_ood, 32'(k == 5));
            check("t1_ready_lo", bus.frame_ready, 0);
            tick();
        end
        check("t1_fl0_en_s", o_en_s, 0);
        check("t1_fl0_bm", o_en_bm, 1);
        check("t1_fl0_acs", o_en_acs, 1);
        check("t1_fl0_tb", o_en_tb, 0);
        tick();
        check("t1_fl1_bm", o_en_bm, 0);
        check("t1_fl1_acs", o_en_acs, 1);
        check("t1_fl1_tb", o_en_tb, 0);
        tick();
        check("t1_tb_rise", o_en_tb, 1);
        check("t1_tb_acs", o_en_acs, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t1_tb_hold", o_en_tb, 1);
        end
        i_tb_done = 1'b1;
        tick();
        i_tb_done = 1'b0;
        check("t1_done", o_done, 1);
        check("t1_tb_drop", o_en_tb, 0);
        check("t1_sym", o_sym_cnt, 6);
        tick();
        check("t1_done_pulse", o_done, 0);
        check("t1_idle", o_busy, 0);
        check("t1_sym_hold", o_sym_cnt, 6);
        check("t1_n_ood", n_ood, 1);

        // Test 2: rate 1/3, three frames with 2-cycle upstream gaps
        clear_mon();
        start_job(1'b1, 16'd3);
        for (int f = 0; f < 3; f++) begin
            for (int g = 0; g < 2; g++) begin
                check("t2_gap_ready", bus.frame_ready, 1);
                check("t2_gap_en_s", o_en_s, 0);
                check("t2_rate", o_rate, 1);
                i_code_rate  = 1'b0;
                i_num_frames = 16'd9;
                tick();
            end
            send_frame(4);
            for (int k = 0; k < 4; k++) begin
                check("t2_en_s", o_en_s, 1);
                tick();
            end
        end
        wait_tb();
        i_tb_done = 1'b1;
        tick();
        i_tb_done = 1'b0;
        check("t2_done", o_done, 1);
        check("t2_sym", o_sym_cnt, 12);
        tick();
        check("t2_n_es", n_es, 12);
        check("t2_n_ood", n_ood, 1);
        check("t2_n_done", n_done, 1);

        // Test 3: zero-frame job
        clear_mon();
        start_job(1'b0, 16'd0);
        check("t3_done", o_done, 1);
        check("t3_busy", o_busy, 1);
        check("t3_ready", bus.frame_ready, 0);
        tick();
        check("t3_done_pulse", o_done, 0);
        check("t3_idle", o_busy, 0);
        check("t3_sym", o_sym_cnt, 0);
        check("t3_n_es", n_es, 0);
        check("t3_n_fr", n_fr, 0);
        check("t3_n_tb", n_tb, 0);
        check("t3_n_done", n_done, 1);

        // Test 4: reset on beat 3 of a rate-1/3 frame
        start_job(1'b1, 16'd1);
        send_frame(4);
        tick(); tick(); tick();
        check("t4_beat3", o_beat, 3);
        check("t4_ood_pre", o_ood, 1);
        rst = 1'b1;
        beat_q.delete();
        tick();
        check("t4_en_s", o_en_s, 0);
        check("t4_en_bm", o_en_bm, 0);
        check("t4_en_acs", o_en_acs, 0);
        check("t4_beat", o_beat, 0);
        check("t4_ood", o_ood, 0);
        check("t4_rate", o_rate, 0);
        check("t4_busy", o_busy, 0);
        check("t4_sym", o_sym_cnt, 0);
        check("t4_ready", bus.frame_ready, 0);
        check("t4_tb", o_en_tb, 0);
        check("t4_done", o_done, 0);
        rst = 1'b0;
        tick();
        check("t4_acs_drained", o_en_acs, 0);
        check("t4_idle", o_busy, 0);

        // Test 5: start and rate toggling mid-slice are ignored
        clear_mon();
        start_job(1'b0, 16'd1);
        send_frame(6);
        i_start      = 1'b1;
        i_num_frames = 16'd5;
        for (int k = 0; k < 6; k++) begin
            check("t5_en_s", o_en_s, 1);
            check("t5_beat", o_beat, k);
            check("t5_rate", o_rate, 0);
            check("t5_busy", o_busy, 1);
            i_code_rate = ~i_code_rate;
            tick();
        end
        i_start = 1'b0;
        check("t5_bpf_end", o_en_s, 0);
        wait_tb();
        i_tb_done = 1'b1;
        tick();
        i_tb_done = 1'b0;
        check("t5_done", o_done, 1);
        check("t5_sym", o_sym_cnt, 6);
        tick();
        check("t5_no_restart", o_busy, 0);
        check("t5_n_es", n_es, 6);

        // Test 6: traceback-done held high from job start
        clear_mon();
        i_tb_done = 1'b1;
        start_job(1'b1, 16'd1);
        check("t6_wait", bus.frame_ready, 1);
        send_frame(4);
        for (int k = 0; k < 4; k++) begin
            check("t6_en_s", o_en_s, 1);
            check("t6_tb_early", o_en_tb, 0);
            tick();
        end
        check("t6_fl0_tb", o_en_tb, 0);
        check("t6_fl0_done", o_done, 0);
        tick();
        check("t6_fl1_tb", o_en_tb, 0);
        tick();
        check("t6_tb", o_en_tb, 1);
        tick();
        check("t6_tb_drop", o_en_tb, 0);
        check("t6_done", o_done, 1);
        i_tb_done = 1'b0;
        tick();
        check("t6_n_tb", n_tb, 1);
        check("t6_idle", o_busy, 0);

        check("queue_empty", beat_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
